// File: rtl/byte_word_packer_pkg.sv
// Shared types for the byte-to-word packer: the word/byte union view,
// lane index and keep types, and the lane-order helper.
package byte_word_packer_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [3:0] byte_keep_t;
    typedef logic [1:0] byte_idx_t;

    typedef struct packed {
        logic [7:0] byte3;
        logic [7:0] byte2;
        logic [7:0] byte1;
        logic [7:0] byte0;
    } word_bytes_t;

    typedef union packed {
        logic [31:0] word;
        word_bytes_t bytes;
    } genericUnion_t;

    // Maps arrival position within a word onto the byte lane it lands in.
    function automatic byte_idx_t lane_of(input byte_idx_t idx, input bit lsb_first);
        return lsb_first ? idx : byte_idx_t'(BYTES_PER_WORD - 1) - idx;
    endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out valid-ready bundle; slave is the packer's view,
// master is the view of whatever drives and consumes it.
interface byte_word_packer_if;
    import byte_word_packer_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    genericUnion_t m_data;
    byte_keep_t    m_keep;
    logic          m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );

endinterface

// File: rtl/byte_word_packer.sv
// Packs an 8-bit valid/ready byte stream into 32-bit words with lane keep,
// last-flag early close and a synchronous abort.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    byte_word_packer_if.slave    bus,
    output logic [CNT_W-1:0]     word_cnt
);

    byte_idx_t     idx;
    byte_idx_t     lane;
    genericUnion_t acc;
    genericUnion_t merged;
    byte_keep_t    acc_keep;
    byte_keep_t    merged_keep;
    logic          accept;
    logic          close;

    // A stalled output word blocks input, so the accumulator can never overrun.
    always_comb begin
        bus.s_ready = !clear && (!bus.m_valid || bus.m_ready);
    end

    always_comb begin
        lane   = lane_of(idx, LSB_FIRST);
        merged = acc;
        case (lane)
            2'd0: merged.bytes.byte0 = bus.s_data;
            2'd1: merged.bytes.byte1 = bus.s_data;
            2'd2: merged.bytes.byte2 = bus.s_data;
            2'd3: merged.bytes.byte3 = bus.s_data;
        endcase
        merged_keep = acc_keep | (byte_keep_t'(1) << lane);
        accept      = bus.s_valid && bus.s_ready;
        close       = bus.s_last || (idx == byte_idx_t'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            acc         <= '0;
            acc_keep    <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_keep  <= '0;
            bus.m_last  <= 1'b0;
            word_cnt    <= '0;
        end else if (clear) begin
            idx         <= '0;
            acc         <= '0;
            acc_keep    <= '0;
            bus.m_valid <= 1'b0;
            bus.m_keep  <= '0;
            bus.m_last  <= 1'b0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
                word_cnt    <= word_cnt + CNT_W'(1);
            end
            // A closing byte reloads the output in the same cycle the old word leaves.
            if (accept) begin
                if (close) begin
                    bus.m_data  <= merged;
                    bus.m_keep  <= merged_keep;
                    bus.m_last  <= bus.s_last;
                    bus.m_valid <= 1'b1;
                    idx         <= '0;
                    acc         <= '0;
                    acc_keep    <= '0;
                end else begin
                    acc      <= merged;
                    acc_keep <= merged_keep;
                    idx      <= idx + byte_idx_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Drives three packer instances (LSB-first, MSB-first, 2-bit counter) from one
// stream and checks them against a byte-queue reference model plus a vector table.
module tb_byte_word_packer;
    import byte_word_packer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    logic [15:0] cnt_lsb;
    logic [15:0] cnt_msb;
    logic [1:0]  cnt_wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_word_packer_if if_lsb ();
    byte_word_packer_if if_msb ();
    byte_word_packer_if if_wrap ();

    assign if_lsb.s_valid  = s_valid;
    assign if_lsb.s_data   = s_data;
    assign if_lsb.s_last   = s_last;
    assign if_lsb.m_ready  = m_ready;
    assign if_msb.s_valid  = s_valid;
    assign if_msb.s_data   = s_data;
    assign if_msb.s_last   = s_last;
    assign if_msb.m_ready  = m_ready;
    assign if_wrap.s_valid = s_valid;
    assign if_wrap.s_data  = s_data;
    assign if_wrap.s_last  = s_last;
    assign if_wrap.m_ready = m_ready;

    byte_word_packer #(.LSB_FIRST(1'b1), .CNT_W(16)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_lsb.slave), .word_cnt(cnt_lsb));
    byte_word_packer #(.LSB_FIRST(1'b0), .CNT_W(16)) dut_msb (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_msb.slave), .word_cnt(cnt_msb));
    byte_word_packer #(.LSB_FIRST(1'b1), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_wrap.slave), .word_cnt(cnt_wrap));

    // Reference model: bytes of the open word in arrival order plus the pending output.
    logic [7:0]  cur_q[$];
    logic        exp_valid;
    logic        exp_last;
    logic        exp_ready;
    logic [31:0] exp_lsb;
    logic [31:0] exp_msb;
    logic [3:0]  exp_keep_lsb;
    logic [3:0]  exp_keep_msb;
    int          exp_cnt;
    logic        ready_seen;

    function void model_reset();
        cur_q.delete();
        exp_valid    = 1'b0;
        exp_last     = 1'b0;
        exp_lsb      = '0;
        exp_msb      = '0;
        exp_keep_lsb = '0;
        exp_keep_msb = '0;
        exp_cnt      = 0;
    endfunction

    function void model_edge();
        logic rdy;
        int   n;
        rdy = !clear && (!exp_valid || m_ready);
        if (clear) begin
            cur_q.delete();
            exp_valid = 1'b0;
            return;
        end
        if (exp_valid && m_ready) begin
            exp_cnt++;
            exp_valid = 1'b0;
        end
        if (s_valid && rdy) begin
            cur_q.push_back(s_data);
            if (cur_q.size() == 4 || s_last) begin
                n       = cur_q.size();
                exp_lsb = '0;
                exp_msb = '0;
                foreach (cur_q[i]) begin
                    exp_lsb |= 32'(cur_q[i]) << (8 * i);
                    exp_msb |= 32'(cur_q[i]) << (8 * (3 - i));
                end
                exp_keep_lsb = 4'((1 << n) - 1);
                exp_keep_msb = 4'(((1 << n) - 1) << (4 - n));
                exp_last     = s_last;
                exp_valid    = 1'b1;
                cur_q.delete();
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_inst(input string tag, input logic mv, input logic [31:0] md,
                              input logic [3:0] mk, input logic ml, input logic [31:0] cnt,
                              input int cnt_exp, input logic [31:0] d_exp, input logic [3:0] k_exp);
        check({tag, " m_valid"}, 32'(mv), 32'(exp_valid));
        check({tag, " word_cnt"}, cnt, 32'(cnt_exp));
        if (exp_valid) begin
            check({tag, " m_data"}, md, d_exp);
            check({tag, " m_keep"}, 32'(mk), 32'(k_exp));
            check({tag, " m_last"}, 32'(ml), 32'(exp_last));
        end
    endtask

    task automatic check_zero(input string tag, input logic mv, input logic [31:0] md,
                              input logic [3:0] mk, input logic ml, input logic [31:0] cnt);
        check({tag, " rst m_valid"}, 32'(mv), 32'd0);
        check({tag, " rst m_data"}, md, 32'd0);
        check({tag, " rst m_keep"}, 32'(mk), 32'd0);
        check({tag, " rst m_last"}, 32'(ml), 32'd0);
        check({tag, " rst word_cnt"}, cnt, 32'd0);
    endtask

    task automatic checkReset();
        check_zero("lsb", if_lsb.m_valid, if_lsb.m_data, if_lsb.m_keep, if_lsb.m_last, 32'(cnt_lsb));
        check_zero("msb", if_msb.m_valid, if_msb.m_data, if_msb.m_keep, if_msb.m_last, 32'(cnt_msb));
        check_zero("wrap", if_wrap.m_valid, if_wrap.m_data, if_wrap.m_keep, if_wrap.m_last, 32'(cnt_wrap));
    endtask

    task automatic checkOutput();
        check_inst("lsb", if_lsb.m_valid, if_lsb.m_data, if_lsb.m_keep, if_lsb.m_last,
                   32'(cnt_lsb), exp_cnt % 65536, exp_lsb, exp_keep_lsb);
        check_inst("msb", if_msb.m_valid, if_msb.m_data, if_msb.m_keep, if_msb.m_last,
                   32'(cnt_msb), exp_cnt % 65536, exp_msb, exp_keep_msb);
        check_inst("wrap", if_wrap.m_valid, if_wrap.m_data, if_wrap.m_keep, if_wrap.m_last,
                   32'(cnt_wrap), exp_cnt % 4, exp_lsb, exp_keep_lsb);
    endtask

    // One cycle: drive at negedge, check s_ready before the edge, outputs after it.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic mr, input logic clr);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        clear   = clr;
        #1;
        exp_ready  = !clr && (!exp_valid || mr);
        ready_seen = if_lsb.s_ready;
        check("lsb s_ready", 32'(if_lsb.s_ready), 32'(exp_ready));
        check("msb s_ready", 32'(if_msb.s_ready), 32'(exp_ready));
        check("wrap s_ready", 32'(if_wrap.s_ready), 32'(exp_ready));
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        mr;
        logic        clr;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
    } vec_t;

    vec_t tbl[$];

    function void add(input logic v, input logic [7:0] d, input logic l, input logic mr,
                      input logic clr, input logic er, input logic ev, input logic [31:0] ed,
                      input logic [3:0] ek, input logic el);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = mr; r.clr = clr;
        r.e_ready = er; r.e_valid = ev; r.e_data = ed; r.e_keep = ek; r.e_last = el;
        tbl.push_back(r);
    endfunction

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        model_reset();
        #12;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s_ready after reset", 32'(if_lsb.s_ready), 32'd1);

        // Full words back to back
        add(1, 8'h11, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h22, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h33, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h44, 0, 1, 0, 1, 1, 32'h44332211, 4'hF, 0);
        add(1, 8'h55, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h66, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h77, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h88, 0, 1, 0, 1, 1, 32'h88776655, 4'hF, 0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        // Partial word, then a one-lane word loaded back to back
        add(1, 8'hA1, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'hB2, 1, 1, 0, 1, 1, 32'h0000B2A1, 4'b0011, 1);
        add(1, 8'h5A, 1, 1, 0, 1, 1, 32'h0000005A, 4'b0001, 1);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        // Backpressure
        add(1, 8'h01, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h02, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h03, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h04, 0, 1, 0, 1, 1, 32'h04030201, 4'hF, 0);
        for (int i = 0; i < 4; i++) add(1, 8'h05, 0, 0, 0, 0, 1, 32'h04030201, 4'hF, 0);
        add(1, 8'h05, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h06, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h07, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h08, 0, 1, 0, 1, 1, 32'h08070605, 4'hF, 0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        // Abort of a partial word
        add(1, 8'hC1, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'hC2, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'hC3, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h02, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h03, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h04, 0, 1, 0, 1, 1, 32'h04030201, 4'hF, 0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        // Abort of a stalled word
        add(1, 8'h09, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 8'h0A, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 8'h0B, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 8'h0C, 0, 0, 0, 1, 1, 32'h0C0B0A09, 4'hF, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1, 32'h0C0B0A09, 4'hF, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr, tbl[i].clr);
            check($sformatf("vec%0d s_ready", i), 32'(ready_seen), 32'(tbl[i].e_ready));
            check($sformatf("vec%0d m_valid", i), 32'(if_lsb.m_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d m_data", i), if_lsb.m_data, tbl[i].e_data);
                check($sformatf("vec%0d m_keep", i), 32'(if_lsb.m_keep), 32'(tbl[i].e_keep));
                check($sformatf("vec%0d m_last", i), 32'(if_lsb.m_last), 32'(tbl[i].e_last));
            end
        end
        check("word_cnt after table", 32'(cnt_lsb), 32'd7);

        // MSB-first lane order
        applyStimulus(1, 8'hDE, 0, 1, 0);
        applyStimulus(1, 8'hAD, 0, 1, 0);
        applyStimulus(1, 8'hBE, 0, 1, 0);
        applyStimulus(1, 8'hEF, 0, 1, 0);
        check("msb DEADBEEF", if_msb.m_data, 32'hDEADBEEF);
        check("msb keep", 32'(if_msb.m_keep), 32'hF);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Asynchronous reset in the middle of a word
        applyStimulus(1, 8'hC1, 0, 1, 0);
        applyStimulus(1, 8'hC2, 0, 1, 0);
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkReset();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 8'h10, 0, 1, 0);
        applyStimulus(1, 8'h20, 0, 1, 0);
        applyStimulus(1, 8'h30, 0, 1, 0);
        applyStimulus(1, 8'h40, 0, 1, 0);
        check("post-reset word", if_lsb.m_data, 32'h40302010);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Counter wrap on the 2-bit instance: one word above, four more here
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                applyStimulus(1, 8'(w * 16 + b), 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        check("wrap word_cnt", 32'(cnt_wrap), 32'd1);
        check("lsb word_cnt 5", 32'(cnt_lsb), 32'd5);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
